mult4_seq: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier. A small FSM reuses a single `adder4` instance over four clock cycles instead of the three adders of the combinational `mult4`. It trades latency for area and presents a start/busy/done handshake to the surrounding logic. It is a drop-in alternative to `mult4` wherever a registered, multi-cycle product is acceptable.

---
 rtl/mult4_seq_pkg.sv | 11 +
 rtl/mult4_seq_if.sv | 12 +
 rtl/mult4_seq_adder4.sv | 9 +
 rtl/mult4_seq.sv | 67 ++++++
 tb/tb_mult4_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult4_seq_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package mult4_seq_pkg;
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  localparam int         MS_STEPS = 4;
  localparam logic [1:0] MS_LAST  = 2'(MS_STEPS - 1);
endpackage

// File: rtl/mult4_seq_if.sv
// Start/busy/done handshake and operand/product bus for mult4_seq.
interface mult4_seq_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] axb;

  modport master (output start, a, b, input  busy, done, axb);
  modport slave  (input  start, a, b, output busy, done, axb);
endinterface

// File: rtl/mult4_seq_adder4.sv
// 4-bit unsigned adder with carry out; the single step datapath of mult4_seq.
module adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier: one adder4 reused over four RUN cycles.
module mult4_seq
  import mult4_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mult4_seq_if.slave bus
);
  ms_state_e  state, state_nxt;
  logic       load, step;
  logic [3:0] a_r, hi, lo, addend, sum;
  logic [1:0] cnt;
  logic       carry;
  logic [7:0] axb_r, prod_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= MS_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      MS_IDLE: if (bus.start) begin load = 1'b1; state_nxt = MS_RUN; end
      MS_RUN: begin
        step = 1'b1;
        if (cnt == MS_LAST) state_nxt = MS_DONE;
      end
      // DONE always leaves after one cycle; a new start chains straight into RUN
      MS_DONE: begin
        if (bus.start) begin load = 1'b1; state_nxt = MS_RUN; end
        else state_nxt = MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  assign addend = lo[0] ? a_r : 4'b0;

  adder4 u_add (.x(hi), .y(addend), .s(sum), .co(carry));

  // carry becomes the new MSB, so the 8-bit {hi,lo} never loses a bit
  assign prod_nxt = {carry, sum, lo[3:1]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      axb_r <= '0;
    end else if (load) begin
      a_r <= bus.a;
      hi  <= '0;
      lo  <= bus.b;
      cnt <= '0;
    end else if (step) begin
      {hi, lo} <= prod_nxt;
      cnt      <= cnt + 2'd1;
      if (cnt == MS_LAST) axb_r <= prod_nxt;
    end

  assign bus.busy = (state == MS_RUN);
  assign bus.done = (state == MS_DONE);
  assign bus.axb  = axb_r;
endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq against a countdown/product reference model.
module tb_mult4_seq;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult4_seq_if bus ();
  mult4_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference: an accepted start yields a*b exactly four edges later.
  int         m_left;
  logic [7:0] m_prod, m_axb;
  logic       m_done;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left <= 0;
      m_prod <= 8'd0;
      m_axb  <= 8'd0;
      m_done <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_axb <= m_prod;
      if (m_left > 0) m_left <= m_left - 1;
      else if (bus.start) begin
        m_left <= 4;
        m_prod <= 8'(bus.a) * 8'(bus.b);
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = 4'd0; bus.b = 4'd0;
    #5;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.axb !== 8'h00) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b axb=%h, want 0 0 00", bus.busy, bus.done, bus.axb);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.axb !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b axb=%h, want 0 0 00", bus.busy, bus.done, bus.axb);
    end
  endtask

  task automatic test_basic;
    int busy_cnt = 0, done_at = -1;
    logic [7:0] got = 8'h00;
    bus.a = 4'd15; bus.b = 4'd15; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.axb !== m_axb) begin
        errors++;
        $display("FAIL basic_c%0d: got busy=%b done=%b axb=%0d, want busy=%b done=%b axb=%0d",
                 c, bus.busy, bus.done, bus.axb, m_left != 0, m_done, m_axb);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_at = c; got = bus.axb; end
      tick;
    end
    checks++;
    if (busy_cnt != 4 || done_at != 4 || got !== 8'hE1) begin
      errors++;
      $display("FAIL basic_15x15: got busy_cycles=%0d done_at=%0d axb=%h, want 4 4 e1", busy_cnt, done_at, got);
    end
  endtask

  task automatic test_operand_change;
    logic [7:0] got;
    for (int t = 0; t < 2; t++) begin
      got = 8'hxx;
      bus.a = (t == 0) ? 4'd0 : 4'd9;
      bus.b = (t == 0) ? 4'd13 : 4'd6;
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.a = 4'd3; bus.b = 4'd3;
      for (int c = 0; c < 6; c++) begin
        checks++;
        if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.axb !== m_axb) begin
          errors++;
          $display("FAIL opchg%0d_c%0d: got busy=%b done=%b axb=%0d, want busy=%b done=%b axb=%0d",
                   t, c, bus.busy, bus.done, bus.axb, m_left != 0, m_done, m_axb);
        end
        if (bus.done) got = bus.axb;
        tick;
      end
      checks++;
      if (got !== ((t == 0) ? 8'd0 : 8'd54)) begin
        errors++;
        $display("FAIL opchg%0d_product: got %0d, want %0d", t, got, (t == 0) ? 0 : 54);
      end
    end
  endtask

  task automatic test_start_ignored;
    int done_cnt = 0, done_at = -1, busy_cnt = 0;
    logic [3:0] ra = 4'($urandom_range(15)), rb = 4'($urandom_range(15));
    logic [7:0] got = 8'h00;
    bus.a = ra; bus.b = rb; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.start = (c == 1);
      checks++;
      if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.axb !== m_axb) begin
        errors++;
        $display("FAIL ignore_c%0d: got busy=%b done=%b axb=%0d, want busy=%b done=%b axb=%0d",
                 c, bus.busy, bus.done, bus.axb, m_left != 0, m_done, m_axb);
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_at = c; got = bus.axb; end
      tick;
    end
    bus.start = 1'b0;
    checks++;
    if (done_cnt != 1 || done_at != 4 || busy_cnt != 4 || got !== 8'(ra) * 8'(rb)) begin
      errors++;
      $display("FAIL ignore_summary: got dones=%0d at=%0d busy=%0d axb=%0d, want 1 4 4 %0d",
               done_cnt, done_at, busy_cnt, got, 8'(ra) * 8'(rb));
    end
  endtask

  task automatic test_reset_midrun;
    int done_cnt = 0;
    bus.a = 4'd7; bus.b = 4'd7; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick; tick;
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.axb !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b axb=%h, want 0 0 00", bus.busy, bus.done, bus.axb);
    end
    #4 rst_n = 1'b1;
    tick;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.axb !== 8'h00) begin
        errors++;
        $display("FAIL midrun_after_c%0d: got busy=%b done=%b axb=%h, want 0 0 00", c, bus.busy, bus.done, bus.axb);
      end
      if (bus.done) done_cnt++;
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int d_at[$];
    logic [7:0] d_val[$];
    bus.a = 4'd5; bus.b = 4'd11; bus.start = 1'b1;
    tick;
    bus.a = 4'd12; bus.b = 4'd10;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.axb !== m_axb || (bus.busy && bus.done)) begin
        errors++;
        $display("FAIL b2b_c%0d: got busy=%b done=%b axb=%0d, want busy=%b done=%b axb=%0d",
                 c, bus.busy, bus.done, bus.axb, m_left != 0, m_done, m_axb);
      end
      if (bus.done) begin d_at.push_back(c); d_val.push_back(bus.axb); end
      if (c == 7) bus.start = 1'b0;
      tick;
    end
    for (int c = 0; c < 6; c++) tick;
    checks++;
    if (d_at.size() != 2 || d_at[0] != 4 || d_at[1] != 9 || d_val[0] !== 8'd55 || d_val[1] !== 8'd120) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses (first at %0d val %0d), want at 4/9 values 55/120",
               d_at.size(), (d_at.size() > 0) ? d_at[0] : -1, (d_val.size() > 0) ? d_val[0] : 8'd0);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] idx, want;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      want = 8'(idx[7:4]) * 8'(idx[3:0]);
      bus.a = idx[7:4]; bus.b = idx[3:0]; bus.start = 1'b1;
      tick;
      for (int k = 1; k <= 4; k++) begin
        bus.a = 4'($urandom); bus.b = 4'($urandom); bus.start = 1'($urandom);
        tick;
        checks++;
        if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.axb !== m_axb) begin
          errors++;
          $display("FAIL sweep_%0dx%0d_k%0d: got busy=%b done=%b axb=%0d, want busy=%b done=%b axb=%0d",
                   idx[7:4], idx[3:0], k, bus.busy, bus.done, bus.axb, m_left != 0, m_done, m_axb);
        end
      end
      checks++;
      if (bus.done !== 1'b1 || bus.axb !== want) begin
        errors++;
        $display("FAIL sweep_%0dx%0d: got done=%b axb=%0d, want done=1 axb=%0d",
                 idx[7:4], idx[3:0], bus.done, bus.axb, want);
      end
    end
    bus.start = 1'b0;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_operand_change;
    test_start_ignored;
    test_reset_midrun;
    test_back_to_back;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
